handshake_constant_buf: RTL and testbench

- Elastic constant source for the handshake dataflow fabric.
- Each token accepted on the control channel produces one token carrying the compile-time constant VALUE on the output channel.
- Tokens are held in a DEPTH-entry occupancy buffer, so ctrl_ready never depends combinationally on outs_ready. This breaks long ready paths between the control network and consumers.
- Because the data is constant, the buffer stores a token count only, never data.

---
 rtl/handshake_constant_buf.sv | 139 +++++++++++++
 tb/tb_handshake_constant_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_constant_buf.sv
// -----------------------------------------------------------------------------
// handshake_constant_buf
//
// Elastic constant source for the handshake dataflow fabric. Every token
// accepted on the control channel produces one output token that carries the
// compile-time constant VALUE. Accepted tokens are held in a DEPTH-entry
// occupancy buffer. ctrl_ready therefore depends only on registered state and
// never on outs_ready, which cuts long ready paths between the control network
// and downstream consumers. Because the payload is constant, the buffer keeps a
// token count and never stores data.
//
// Parameters:
//   DATA_WIDTH  width of outs
//   VALUE       constant emitted on outs, truncated to DATA_WIDTH bits
//   DEPTH       token capacity, must be >= 1
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous reset, active-low (0 = reset)
//   ctrl_valid  control token offered
//   ctrl_ready  block can accept a control token
//   outs        constant data (VALUE while outs_valid, else zero)
//   outs_valid  constant token available
//   outs_ready  consumer accepts token
//   occupancy   tokens currently held ($clog2(DEPTH+1) bits, 0 during reset)
//   xfer_count  32-bit count of completed output transfers
//               (present only when HANDSHAKE_CONST_XFER_CNT_EN is defined)
//
// Optional feature macro: HANDSHAKE_CONST_XFER_CNT_EN
// -----------------------------------------------------------------------------
module handshake_constant_buf #(
  parameter int DATA_WIDTH = 32,
  parameter     VALUE      = 0,
  parameter int DEPTH      = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CW-1:0]         occupancy
`ifdef HANDSHAKE_CONST_XFER_CNT_EN
  ,
  output logic [31:0]           xfer_count
`endif
);

  // A zero-capacity buffer could never accept a token; refuse to elaborate.
  if (DEPTH < 1) begin : g_depth_check
    $error("handshake_constant_buf: DEPTH must be at least 1");
  end

  localparam logic [DATA_WIDTH-1:0] CONST_DATA = DATA_WIDTH'(VALUE);
  localparam logic [CW-1:0]         FULL       = CW'(DEPTH);
  localparam logic [CW-1:0]         ONE        = CW'(1);

  // NOTE: only the token count is state. There is no data array, so reset
  // clears the counter and nothing else needs initialising.
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  // Ready and valid are functions of the registered count (and reset) only.
  // Forcing both low while rst=0 keeps any handshake from completing during
  // reset, including a reset that lands in the middle of traffic.
  assign ctrl_ready = rst & (count < FULL);
  assign outs_valid = rst & (count != '0);
  assign outs       = outs_valid ? CONST_DATA : '0;
  assign occupancy  = rst ? count : '0;

  assign push = ctrl_valid & ctrl_ready;
  assign pop  = outs_valid & outs_ready;

  // NOTE: every always_comb output gets a default on entry; a path that leaves
  // count_next unassigned would infer a latch.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + ONE;
      2'b01:   count_next = count - ONE;
      default: count_next = count;  // both or neither: occupancy unchanged
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

`ifdef HANDSHAKE_CONST_XFER_CNT_EN
  // Completed output transfers; wraps naturally at 2^32. The current-cycle pop
  // becomes visible on the following cycle.
  logic [31:0] xfer_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      xfer_count_q <= '0;
    end else if (pop) begin
      xfer_count_q <= xfer_count_q + 32'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

  // ---------------------------------------------------------------------------
  // Simulation-time invariants
  // ---------------------------------------------------------------------------
  // The counter stays within 0..DEPTH.
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= FULL);

  // A push never lands on a full buffer unless a pop frees the slot in the same
  // cycle (which cannot happen, since ready is low when full).
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == FULL)));

  // A pop never happens on an empty buffer.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && (count == '0)));

  // Once offered, a token stays offered until it is taken.
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst)
    (outs_valid && !outs_ready) |=> outs_valid);

  // Data is the constant whenever it is offered.
  a_data_const: assert property (@(posedge clk) disable iff (!rst)
    outs_valid |-> (outs == CONST_DATA));

endmodule

// File: tb/tb_handshake_constant_buf.sv
// -----------------------------------------------------------------------------
// Self-checking bench for handshake_constant_buf.
//   dut  : DATA_WIDTH=19, VALUE=19'h35562, DEPTH=2 (table vectors, model-driven
//          sequences, scoreboard of emitted tokens)
//   dut1 : same constant, DEPTH=1 (alternating-ready throughput)
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_handshake_constant_buf;

  localparam int              DW    = 19;
  localparam logic [DW-1:0]   VAL   = 19'h35562;
  localparam int              DEPTH = 2;
  localparam int              CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready;
  logic [CW-1:0] occupancy;

  logic          ctrl_valid1;
  logic          ctrl_ready1;
  logic [DW-1:0] outs1;
  logic          outs_valid1;
  logic          outs_ready1;
  logic [0:0]    occupancy1;

`ifdef HANDSHAKE_CONST_XFER_CNT_EN
  logic [31:0]   xfer_count;
  logic [31:0]   xfer_count1;
`endif

  always #5 clk = ~clk;

  handshake_constant_buf #(.DATA_WIDTH(DW), .VALUE(VAL), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .occupancy  (occupancy)
`ifdef HANDSHAKE_CONST_XFER_CNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  handshake_constant_buf #(.DATA_WIDTH(DW), .VALUE(VAL), .DEPTH(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid1),
    .ctrl_ready (ctrl_ready1),
    .outs       (outs1),
    .outs_valid (outs_valid1),
    .outs_ready (outs_ready1),
    .occupancy  (occupancy1)
`ifdef HANDSHAKE_CONST_XFER_CNT_EN
    ,
    .xfer_count (xfer_count1)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping, reference model, scoreboard
  // ---------------------------------------------------------------------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            model_cnt = 0;
  logic [31:0]   model_xfer = '0;
  logic [DW-1:0] sb[$];
  int            n_pops = 0;
  int            n_accepts = 0;
  int            n_notready = 0;

  typedef struct packed {
    logic          r;
    logic          cv;
    logic          ordy;
    logic          rdy;
    logic          vld;
    logic [CW-1:0] occ;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  function automatic vec_t v(input int r, cv, ordy, rdy, vld, occ);
    vec_t f;
    f.r    = r[0];
    f.cv   = cv[0];
    f.ordy = ordy[0];
    f.rdy  = rdy[0];
    f.vld  = vld[0];
    f.occ  = occ[CW-1:0];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle on the DEPTH=2 instance: drive, compare against the supplied
  // expectations, run the scoreboard, then advance the bench model.
  task automatic drive_and_check(input string tag, input logic r, cv, ordy,
                                 input logic e_rdy, e_vld, input logic [CW-1:0] e_occ);
    logic [DW-1:0] exp_tok;
    @(negedge clk);
    rst        = r;
    ctrl_valid = cv;
    outs_ready = ordy;
    #1;
    check({tag, ".ctrl_ready"}, 32'(ctrl_ready), 32'(e_rdy));
    check({tag, ".outs_valid"}, 32'(outs_valid), 32'(e_vld));
    check({tag, ".occupancy"},  32'(occupancy),  32'(e_occ));
    check({tag, ".outs"},       32'(outs),       e_vld ? 32'(VAL) : 32'd0);
`ifdef HANDSHAKE_CONST_XFER_CNT_EN
    check({tag, ".xfer_count"}, xfer_count, model_xfer);
`endif
    if (e_rdy && cv) sb.push_back(VAL);
    if (outs_valid && ordy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.sb_pop: got token %h expected none", tag, outs);
      end else begin
        exp_tok = sb.pop_front();
        check({tag, ".sb_data"}, 32'(outs), 32'(exp_tok));
      end
      n_pops++;
    end
    if (ctrl_ready && cv) n_accepts++;
    if (!ctrl_ready) n_notready++;
    if (!r) begin
      model_cnt  = 0;
      model_xfer = '0;
      sb.delete();
    end else begin
      model_cnt  = model_cnt + int'(e_rdy && cv) - int'(e_vld && ordy);
      model_xfer = model_xfer + 32'(e_vld && ordy);
    end
  endtask

  // Same, with expectations derived from the bench model.
  task automatic mcycle(input string tag, input logic r, cv, ordy);
    logic e_rdy;
    logic e_vld;
    e_rdy = r && (model_cnt < DEPTH);
    e_vld = r && (model_cnt != 0);
    drive_and_check(tag, r, cv, ordy, e_rdy, e_vld, r ? CW'(model_cnt) : '0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc_base;
    int pop_base;
    int nr_base;
    int acc1;

    rst = 1'b0; ctrl_valid = 1'b0; outs_ready = 1'b0;
    ctrl_valid1 = 1'b0; outs_ready1 = 1'b0;

    //           r cv or rdy vld occ
    tbl[0]  = v(0, 1, 1, 0, 0, 0);  // reset held, inputs active
    tbl[1]  = v(0, 1, 1, 0, 0, 0);
    tbl[2]  = v(0, 1, 1, 0, 0, 0);
    tbl[3]  = v(1, 0, 1, 1, 0, 0);  // first cycle after release
    tbl[4]  = v(1, 1, 1, 1, 0, 0);  // single pulse, no bypass
    tbl[5]  = v(1, 0, 1, 1, 1, 1);  // visible one cycle later, popped
    tbl[6]  = v(1, 0, 1, 1, 0, 0);
    tbl[7]  = v(1, 1, 0, 1, 0, 0);  // back-pressure fill
    tbl[8]  = v(1, 1, 0, 1, 1, 1);
    tbl[9]  = v(1, 1, 0, 0, 1, 2);  // full
    tbl[10] = v(1, 1, 0, 0, 1, 2);
    tbl[11] = v(1, 0, 1, 0, 1, 2);  // drain 2 -> 1 -> 0
    tbl[12] = v(1, 0, 1, 1, 1, 1);
    tbl[13] = v(1, 0, 1, 1, 0, 0);
    tbl[14] = v(1, 1, 0, 1, 0, 0);  // refill
    tbl[15] = v(1, 1, 0, 1, 1, 1);
    tbl[16] = v(1, 1, 1, 0, 1, 2);  // full: ready stays low despite outs_ready
    tbl[17] = v(1, 1, 1, 1, 1, 1);  // push and pop together
    tbl[18] = v(1, 0, 1, 1, 1, 1);
    tbl[19] = v(1, 0, 0, 1, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      if (i == 7) acc_base = n_accepts;
      drive_and_check($sformatf("vec%0d", i), tbl[i].r, tbl[i].cv, tbl[i].ordy,
                      tbl[i].rdy, tbl[i].vld, tbl[i].occ);
      if (i == 10) check("bp_accepts", 32'(n_accepts - acc_base), 32'd2);
    end

    // Streaming, DEPTH=2: one token per cycle, ready never drops.
    pop_base = n_pops;
    nr_base  = n_notready;
    for (int i = 0; i < 100; i++) mcycle($sformatf("stream%0d", i), 1'b1, 1'b1, 1'b1);
    check("stream_pops", 32'(n_pops - pop_base), 32'd99);
    check("stream_notready", 32'(n_notready - nr_base), 32'd0);
    mcycle("stream_drain", 1'b1, 1'b0, 1'b1);
    mcycle("stream_idle", 1'b1, 1'b0, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // Mid-operation reset with two tokens held.
    mcycle("mr_fill0", 1'b1, 1'b1, 1'b0);
    mcycle("mr_fill1", 1'b1, 1'b1, 1'b0);
    mcycle("mr_rst", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) mcycle($sformatf("mr_after%0d", i), 1'b1, 1'b0, 1'b1);

`ifdef HANDSHAKE_CONST_XFER_CNT_EN
    // Transfer counter wrap: deposit just after an edge with no pop pending.
    mcycle("xc_idle", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    dut.xfer_count_q = 32'hFFFF_FFFE;
    model_xfer       = 32'hFFFF_FFFE;
    mcycle("xc_push", 1'b1, 1'b1, 1'b0);
    mcycle("xc_pop0", 1'b1, 1'b1, 1'b1);
    mcycle("xc_pop1", 1'b1, 1'b1, 1'b1);
    mcycle("xc_pop2", 1'b1, 1'b0, 1'b1);
    mcycle("xc_end", 1'b1, 1'b0, 1'b0);
    check("xc_wrapped", xfer_count, 32'd1);
`endif

    mcycle("park", 1'b1, 1'b0, 1'b0);

    // Streaming, DEPTH=1: ready alternates, one accept every two cycles.
    acc1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ctrl_valid1 = 1'b1;
      outs_ready1 = 1'b1;
      #1;
      check($sformatf("d1_%0d.ctrl_ready", i), 32'(ctrl_ready1), 32'(i % 2 == 0));
      check($sformatf("d1_%0d.outs_valid", i), 32'(outs_valid1), 32'(i % 2 == 1));
      check($sformatf("d1_%0d.occupancy", i),  32'(occupancy1),  32'(i % 2 == 1));
      check($sformatf("d1_%0d.outs", i), 32'(outs1), (i % 2 == 1) ? 32'(VAL) : 32'd0);
      if (ctrl_ready1) acc1++;
    end
    @(negedge clk);
    ctrl_valid1 = 1'b0;
    outs_ready1 = 1'b0;
    check("d1_accepts", 32'(acc1), 32'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
